dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port, word-addressed data memory (asynchronous read, synchronous write) between the CPU load/store unit (port 0) and the debug/program-loader master (port 1). It grants at most one access per cycle, drives the memory's we/addr/wdata, and registers the combinational read data into a one-cycle-latency response per port. It also supports locked sequences (read-modify-write, burst load) with a timeout watchdog, and rejects misaligned or out-of-range accesses.

## Interface
- ADDR_LIMIT, 4096: byte size of the memory; any address >= ADDR_LIMIT is an error.
- LOCK_TIMEOUT, 16: max cycles a port may hold lock (>= 2).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- p0_req / p1_req  in  1  access request, held until granted.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_lock / p1_lock  in  1  request exclusive ownership after this grant.
- p0_addr / p1_addr  in  32  byte address.
- p0_wdata / p1_wdata  in  32  write data.
- p0_gnt / p1_gnt  out  1  combinational grant, same cycle as the access.
- p0_rvalid / p1_rvalid  out  1  registered response strobe, one cycle after grant.
- p0_rdata / p1_rdata  out  32  registered read data (0 for writes and errors).
- p0_err / p1_err  out  1  registered error, qualified by rvalid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory asynchronous read data.
- lock_abort  out  1  one-cycle pulse when the watchdog forcibly releases a lock.

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Reset -> IDLE.
- IDLE: if exactly one port requests, grant it. If both request, round-robin: grant the port != last_gnt. last_gnt resets to 1, so port 0 wins the first contention.
- last_gnt updates to the granted port on every grant.
- LOCKp is entered from any state at the end of a cycle in which port p is granted with p_lock=1 and p's block flag is clear.
- LOCKp: only port p may be granted. The other port's requests stall, with no grant.
- Leaving LOCKp:
  - -> IDLE at the end of any cycle with p_lock=0, whether or not p was granted.
  - -> IDLE on watchdog expiry.
- Watchdog:
  - Counter is cleared on lock entry and increments every cycle in LOCKp.
  - At count == LOCK_TIMEOUT-1 with p_lock still high: next state is IDLE, lock_abort=1 next cycle, and block flag p is set.
  - last_gnt forced to p, so the other port wins any contention.
- Block flag p: prevents LOCKp re-entry. It clears on the first cycle p_lock=0. Port p can still get unlocked grants.
- Error: granted access with addr[1:0] != 0 or addr >= ADDR_LIMIT. Still consumes the grant, but mem_we is forced to 0. Response has err=1, rdata=0. A locking error access still enters lock.
- Memory drive:
  - With a grant: mem_addr / mem_wdata = granted port's values; mem_we = we & ~err.
  - With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- Response: every granted access (read, write or error) produces p_rvalid=1 for exactly one cycle on the next cycle. p_rdata = registered mem_rdata for good reads, else 0.
- Reset values: all gnt, rvalid, err, lock_abort = 0; rdata = 0; counter = 0; block flags = 0; state IDLE.

## Timing
- Grant latency: 0 cycles; gnt is combinational from req, state and last_gnt. Read response latency: 1 cycle.
- Throughput: 1 access/cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Write lands at the grant-cycle edge. A read to the same address in the next cycle returns the new data.
- Requester may change addr/we/wdata only after the gnt cycle.
- rst in the middle of a lock: next cycle is IDLE, with no abort pulse. A response pending from the pre-reset cycle is discarded (rvalid=0).

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: IDLE contention always grants port 0, and last_gnt is ignored for arbitration. Lock and watchdog are unchanged, but after an abort of port 0, port 1 wins only the very next contended cycle.
- Not defined: round-robin as described above.

## Test plan
- Reset, then p0 writes 0xDEADBEEF @0x10 and p0 reads @0x10 next cycle -> gnt0 both cycles; rvalid0 on the cycle after the read, with rdata0=0xDEADBEEF and err0=0.
- p0 and p1 both reading continuously from reset -> grants alternate 0,1,0,1; each rvalid follows its gnt by 1 cycle. With DMEM_ARB_FIXED_PRIO_EN, gnt0 every cycle and p1 is starved.
- p1 lock read @0x20, modify, write @0x20 with lock=0 while p0 requests -> gnt0 stays low until the cycle after p1's unlocked write; then gnt0=1.
- p1 holds lock=1 for 20 cycles with LOCK_TIMEOUT=16 -> state returns to IDLE after 16 lock cycles, and lock_abort pulses once. p0 gets the next contended grant, and p1 cannot relock until lock1 has been low for a cycle.
- p0 write @0x13 and p1 read @0x1000 (ADDR_LIMIT=4096) -> mem_we=0 on both grants; err=1 with rdata=0 in each response.
- rst asserted in the middle of LOCK0 with a read pending -> next cycle all outputs are 0 and state is IDLE; p1 is granted immediately when requesting.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Shared bus between the two data-memory requesters, the arbiter and the memory.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic        p0_lock;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic        p1_lock;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        lock_abort;

  modport slave (
    input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output lock_abort
  );

  modport master (
    output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  lock_abort
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin, locked sequences and a lock watchdog.
// Optional: define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority on contention.
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT   = 4096,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input logic            clk,
  input logic            rst,
  dmem_arbiter_if.slave  bus
);
  localparam int CNT_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         blk_q, blk_d;
  logic               last_gnt_q, last_gnt_d;
  logic               abort_q, abort_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  logic               pref1_q, pref1_d;
`endif

  logic [1:0]         req, we, lock, gnt, err_acc;
  logic [31:0]        addr [2];
  logic [31:0]        wdata [2];
  logic [1:0]         rvalid_q, err_q;
  logic [31:0]        rdata_q [2];

  assign req      = {bus.p1_req, bus.p0_req};
  assign we       = {bus.p1_we, bus.p0_we};
  assign lock     = {bus.p1_lock, bus.p0_lock};
  assign addr[0]  = bus.p0_addr;
  assign addr[1]  = bus.p1_addr;
  assign wdata[0] = bus.p0_wdata;
  assign wdata[1] = bus.p1_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign err_acc[gi] = (addr[gi][1:0] != 2'b00) || (addr[gi] >= 32'(ADDR_LIMIT));

      // A pending response is dropped by reset; rdata is zero unless it was a clean read.
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_q[gi] <= 1'b0;
          err_q[gi]    <= 1'b0;
          rdata_q[gi]  <= '0;
        end else begin
          rvalid_q[gi] <= gnt[gi];
          err_q[gi]    <= gnt[gi] & err_acc[gi];
          rdata_q[gi]  <= (gnt[gi] & ~we[gi] & ~err_acc[gi]) ? bus.mem_rdata : 32'h0;
        end
      end
    end
  endgenerate

  always_comb begin
    gnt = 2'b00;
    case (state_q)
      IDLE: begin
        if (req == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          gnt = pref1_q ? 2'b10 : 2'b01;
`else
          gnt = last_gnt_q ? 2'b01 : 2'b10;
`endif
        end else begin
          gnt = req;
        end
      end
      LOCK0:   gnt = {1'b0, req[0]};
      LOCK1:   gnt = {req[1], 1'b0};
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    last_gnt_d = last_gnt_q;
    abort_d    = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pref1_d    = pref1_q;
    if (state_q == IDLE && req == 2'b11) pref1_d = 1'b0;
`endif
    if (gnt[0]) last_gnt_d = 1'b0;
    if (gnt[1]) last_gnt_d = 1'b1;
    for (int p = 0; p < 2; p++) begin
      if (!lock[p]) blk_d[p] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (gnt[0] && lock[0] && !blk_q[0]) begin
          state_d = LOCK0;
          cnt_d   = '0;
        end else if (gnt[1] && lock[1] && !blk_q[1]) begin
          state_d = LOCK1;
          cnt_d   = '0;
        end
      end
      LOCK0: begin
        if (!lock[0]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          // Forced release: the victim is blocked and loses the next contention.
          state_d    = IDLE;
          abort_d    = 1'b1;
          blk_d[0]   = 1'b1;
          last_gnt_d = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
          pref1_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCK1: begin
        if (!lock[1]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d    = IDLE;
          abort_d    = 1'b1;
          blk_d[1]   = 1'b1;
          last_gnt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      blk_q      <= 2'b00;
      last_gnt_q <= 1'b1;
      abort_q    <= 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      pref1_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      last_gnt_q <= last_gnt_d;
      abort_q    <= abort_d;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      pref1_q    <= pref1_d;
`endif
    end
  end

  assign bus.mem_we     = |(gnt & we & ~err_acc);
  assign bus.mem_addr   = gnt[0] ? addr[0]  : (gnt[1] ? addr[1]  : 32'h0);
  assign bus.mem_wdata  = gnt[0] ? wdata[0] : (gnt[1] ? wdata[1] : 32'h0);

  assign bus.p0_gnt     = gnt[0];
  assign bus.p1_gnt     = gnt[1];
  assign bus.p0_rvalid  = rvalid_q[0];
  assign bus.p1_rvalid  = rvalid_q[1];
  assign bus.p0_err     = err_q[0];
  assign bus.p1_err     = err_q[1];
  assign bus.p0_rdata   = rdata_q[0];
  assign bus.p1_rdata   = rdata_q[1];
  assign bus.lock_abort = abort_q;
endmodule
